// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-master sram-like request arbiter:
//   - access size encodings used on the sram-like bus
//   - master IDs (instruction fetch vs. exe-stage data port)
//   - grant FSM state encoding
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic MASTER_INST = 1'b0;
    localparam logic MASTER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// ---------------------------------------------------------------------------
// arb_id_fifo
// Small in-order FIFO of 1-bit master IDs. The arbiter pushes the ID of each
// accepted request and pops on each downstream response, so the head always
// names the master that owns the next response.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   push, push_id     enqueue push_id this cycle
//   pop               dequeue the head this cycle
//   head_id           ID at the head (meaningless while empty)
//   cnt               number of stored IDs (0..DEPTH)
//   full, empty       occupancy flags
// Simultaneous push and pop keeps cnt unchanged and advances both pointers.
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   push_id,
    input  logic                   pop,
    output logic                   head_id,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is dropped; a push while full is only
    // allowed when the same cycle frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign head_id = mem[rd_ptr];

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Two-master arbiter for the sram-like req/addr_ok/data_ok protocol.
// Master 0 is instruction fetch, master 1 is the exe-stage data port. Both
// are muxed onto one downstream sram-like port with zero-cycle arbitration;
// an in-order ID FIFO routes each downstream data_ok back to its issuer.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   mN_req/wr/size/wstrb/addr/wdata   master N request (held until addr_ok)
//   mN_addr_ok, mN_data_ok, mN_rdata  master N handshake and read data
//   s_req/wr/size/wstrb/addr/wdata    downstream request
//   s_addr_ok, s_data_ok, s_rdata     downstream handshake and read data
//   busy                     a request is outstanding or a grant is locked
//
// Build option:
//   SRAM_ARB_RR_EN  defined   -> round-robin on ties (last_grant register)
//                   undefined -> fixed priority, m1 over m0
// ---------------------------------------------------------------------------
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTS_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                m0_req,
    input  logic                m0_wr,
    input  logic [1:0]          m0_size,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_addr_ok,
    output logic                m0_data_ok,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_wr,
    input  logic [1:0]          m1_size,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_addr_ok,
    output logic                m1_data_ok,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_req,
    output logic                s_wr,
    output logic [1:0]          s_size,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    input  logic                s_addr_ok,
    input  logic                s_data_ok,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(OUTS_DEPTH) + 1;

    arb_state_e       state;
    arb_state_e       state_next;
    logic             sel;
    logic             win;
    logic             any_req;
    logic             accept;
    logic             resp;
    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;

    assign any_req = m0_req | m1_req;

`ifdef SRAM_ARB_RR_EN
    logic last_grant;

    // Remembers who won the most recent accepted request; starting at 1
    // makes the very first tie go to the instruction port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= sel;
        end
    end

    // On a tie the master that did not win last time goes first.
    always_comb begin
        if (m0_req && m1_req) begin
            win = ~last_grant;
        end else begin
            win = m1_req ? MASTER_DATA : MASTER_INST;
        end
    end
`else
    // Fixed priority: the data port beats instruction fetch.
    assign win = m1_req ? MASTER_DATA : MASTER_INST;
`endif

    // Grant state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Selection and next state. In IDLE the winner drives the bus in the
    // same cycle; if it is not accepted the grant is locked to it so the
    // downstream sees a stable request until addr_ok. s_req is held low
    // while resetn is asserted so the bus is quiet during reset.
    always_comb begin
        state_next = state;
        sel        = win;
        s_req      = 1'b0;
        case (state)
            ST_IDLE: begin
                sel   = win;
                s_req = any_req & ~fifo_full & resetn;
                if (s_req && !s_addr_ok) begin
                    state_next = (sel == MASTER_DATA) ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0: begin
                sel   = MASTER_INST;
                s_req = m0_req & resetn;
                if (s_req && s_addr_ok) state_next = ST_IDLE;
            end
            ST_LOCK1: begin
                sel   = MASTER_DATA;
                s_req = m1_req & resetn;
                if (s_req && s_addr_ok) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign s_wr    = (sel == MASTER_DATA) ? m1_wr    : m0_wr;
    assign s_size  = (sel == MASTER_DATA) ? m1_size  : m0_size;
    assign s_wstrb = (sel == MASTER_DATA) ? m1_wstrb : m0_wstrb;
    assign s_addr  = (sel == MASTER_DATA) ? m1_addr  : m0_addr;
    assign s_wdata = (sel == MASTER_DATA) ? m1_wdata : m0_wdata;

    assign accept     = s_req & s_addr_ok;
    assign m0_addr_ok = accept & (sel == MASTER_INST);
    assign m1_addr_ok = accept & (sel == MASTER_DATA);

    // A response with nothing outstanding is a protocol error and is dropped.
    assign resp       = s_data_ok & ~fifo_empty;
    assign m0_data_ok = resp & (fifo_head == MASTER_INST);
    assign m1_data_ok = resp & (fifo_head == MASTER_DATA);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    assign busy = (fifo_cnt != '0) | (state != ST_IDLE);

    arb_id_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (sel),
        .pop     (s_data_ok),
        .head_id (fifo_head),
        .cnt     (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        !(s_data_ok && fifo_empty));

endmodule

// File: tb/tb_sram_req_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Self-checking bench for sram_req_arbiter: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a queue-based reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int OUTS_DEPTH = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam logic [31:0] A0 = 32'h1C00_0000;
    localparam logic [31:0] A1 = 32'h8000_0000;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                resetn = 1'b1;
    logic                m0_req = 1'b0, m1_req = 1'b0;
    logic                m0_wr, m1_wr;
    logic [1:0]          m0_size, m1_size;
    logic [DATA_W/8-1:0] m0_wstrb, m1_wstrb;
    logic [ADDR_W-1:0]   m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0]   m0_wdata, m1_wdata;
    logic                m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
    logic [DATA_W-1:0]   m0_rdata, m1_rdata;
    logic                s_req, s_wr;
    logic [1:0]          s_size;
    logic [DATA_W/8-1:0] s_wstrb;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic                s_addr_ok = 1'b0, s_data_ok = 1'b0;
    logic [DATA_W-1:0]   s_rdata = '0;
    logic                busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Side-band request fields are derived from the address so that the
    // mux of every field can be checked without extra stimulus columns.
    function automatic logic [1:0] size_of(input logic [31:0] a);
        return (a[1:0] == 2'b11) ? SIZE_WORD : a[1:0];
    endfunction
    function automatic logic [38:0] side_of(input logic [31:0] a);
        return {a[2], size_of(a), a[7:4], ~a};
    endfunction

    assign m0_wr = m0_addr[2];
    assign m1_wr = m1_addr[2];
    assign m0_size = size_of(m0_addr);
    assign m1_size = size_of(m1_addr);
    assign m0_wstrb = m0_addr[7:4];
    assign m1_wstrb = m1_addr[7:4];
    assign m0_wdata = ~m0_addr;
    assign m1_wdata = ~m1_addr;

    sram_req_arbiter #(
        .OUTS_DEPTH (OUTS_DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_wstrb   (m0_wstrb),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m1_rdata   (m1_rdata),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata),
        .busy       (busy)
    );

    typedef struct {
        logic        m0_req, m1_req;
        logic [31:0] m0_addr, m1_addr;
        logic        s_aok, s_dok;
        logic [31:0] s_rdata;
    } stim_t;

    typedef struct {
        logic sreq, sel, aok0, aok1, dok0, dok1, busy;
    } exp_t;

    typedef struct {
        stim_t       in;
        logic        sreq;
        logic [31:0] saddr;
        logic        aok0, aok1, dok0, dok1, busy;
        logic [31:0] rdata;
    } vec_t;

    // Reference model: queue of owners of outstanding requests, the master
    // a grant is locked to (-1 for none) and the last winner.
    int    q[$];
    int    lock = -1;
    bit    last = 1'b1;
    stim_t cur;

    function automatic void model_reset();
        q.delete();
        lock = -1;
        last = 1'b1;
    endfunction

    function automatic exp_t model_eval(input stim_t s);
        exp_t e;
        e = '{default: 1'b0};
        e.busy = (q.size() != 0) || (lock >= 0);
        if (lock >= 0) begin
            e.sel  = (lock == 1);
            e.sreq = (lock == 1) ? s.m1_req : s.m0_req;
        end else if (q.size() < OUTS_DEPTH && (s.m0_req || s.m1_req)) begin
            e.sreq = 1'b1;
            if (s.m0_req && s.m1_req) e.sel = RR ? !last : 1'b1;
            else                      e.sel = s.m1_req;
        end
        e.aok0 = e.sreq && s.s_aok && !e.sel;
        e.aok1 = e.sreq && s.s_aok && e.sel;
        if (s.s_dok && q.size() > 0) begin
            if (q[0] == 0) e.dok0 = 1'b1;
            else           e.dok1 = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_advance(input stim_t s, input exp_t e);
        if (e.dok0 || e.dok1) void'(q.pop_front());
        if (e.sreq && s.s_aok) begin
            q.push_back(int'(e.sel));
            last = e.sel;
        end
        if (lock >= 0) begin
            if (s.s_aok) lock = -1;
        end else if (e.sreq && !s.s_aok) begin
            lock = int'(e.sel);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    stim_t idle_s;

    function automatic stim_t mk_stim(input bit m0r, input bit m1r, input bit aok,
                                      input bit dok, input logic [31:0] rd);
        stim_t s;
        s.m0_req = m0r; s.m1_req = m1r; s.m0_addr = A0; s.m1_addr = A1;
        s.s_aok = aok; s.s_dok = dok; s.s_rdata = rd;
        return s;
    endfunction

    // Drives one cycle of stimulus at the falling edge and lets it settle.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur       = s;
        m0_req    = s.m0_req;
        m1_req    = s.m1_req;
        m0_addr   = s.m0_addr;
        m1_addr   = s.m1_addr;
        s_addr_ok = s.s_aok;
        s_data_ok = s.s_dok;
        s_rdata   = s.s_rdata;
        #2;
    endtask

    // Compares the settled outputs with the model, then steps the model
    // across the rising edge together with the DUT.
    task automatic model_step(input string tag, output exp_t e);
        e = model_eval(cur);
        checkOutput({tag, "_s_req"}, s_req, e.sreq);
        checkOutput({tag, "_m0_addr_ok"}, m0_addr_ok, e.aok0);
        checkOutput({tag, "_m1_addr_ok"}, m1_addr_ok, e.aok1);
        checkOutput({tag, "_m0_data_ok"}, m0_data_ok, e.dok0);
        checkOutput({tag, "_m1_data_ok"}, m1_data_ok, e.dok1);
        checkOutput({tag, "_busy"}, busy, e.busy);
        if (e.sreq) begin
            checkOutput({tag, "_s_addr"}, s_addr, e.sel ? cur.m1_addr : cur.m0_addr);
            checkOutput({tag, "_s_side"}, {s_wr, s_size, s_wstrb, s_wdata},
                        side_of(e.sel ? cur.m1_addr : cur.m0_addr));
        end
        if (e.dok0) checkOutput({tag, "_m0_rdata"}, m0_rdata, cur.s_rdata);
        if (e.dok1) checkOutput({tag, "_m1_rdata"}, m1_rdata, cur.s_rdata);
        @(posedge clk);
        model_advance(cur, e);
    endtask

    task automatic do_cycle(input string tag, input stim_t s);
        exp_t e;
        applyStimulus(s);
        model_step(tag, e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * OUTS_DEPTH && q.size() > 0; i++) begin
            do_cycle(tag, mk_stim(0, 0, 0, 1, $urandom));
        end
        checkOutput({tag, "_drained"}, q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    vec_t tbl[11];

    function automatic vec_t mk(input bit m0r, input bit m1r, input bit aok,
                                input bit dok, input logic [31:0] rd,
                                input bit esreq, input logic [31:0] eaddr,
                                input bit ea0, input bit ea1, input bit ed0,
                                input bit ed1, input bit eb);
        vec_t v;
        v.in = mk_stim(m0r, m1r, aok, dok, rd);
        v.sreq = esreq; v.saddr = eaddr; v.aok0 = ea0; v.aok1 = ea1;
        v.dok0 = ed0; v.dok1 = ed1; v.busy = eb; v.rdata = rd;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        bit   rq[2];
        logic [31:0] ad[2];

        idle_s = mk_stim(0, 0, 0, 0, 0);

        // Table: simultaneous requests, then a locked grant to m0.
`ifdef SRAM_ARB_RR_EN
        tbl[0] = mk(1, 1, 1, 0, 0,            1, A0, 1, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 1, 0, 0,            1, A1, 0, 1, 0, 0, 1);
        tbl[2] = mk(0, 0, 0, 1, 32'h11111111, 0, 0,  0, 0, 1, 0, 1);
        tbl[3] = mk(0, 0, 0, 1, 32'h22222222, 0, 0,  0, 0, 0, 1, 1);
`else
        tbl[0] = mk(1, 1, 1, 0, 0,            1, A1, 0, 1, 0, 0, 0);
        tbl[1] = mk(1, 0, 1, 0, 0,            1, A0, 1, 0, 0, 0, 1);
        tbl[2] = mk(0, 0, 0, 1, 32'h11111111, 0, 0,  0, 0, 0, 1, 1);
        tbl[3] = mk(0, 0, 0, 1, 32'h22222222, 0, 0,  0, 0, 1, 0, 1);
`endif
        tbl[4]  = mk(1, 0, 0, 0, 0,            1, A0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0, 0, 0,            1, A0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 1, 0, 0, 0,            1, A0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 1, 0, 0,            1, A0, 1, 0, 0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 0, 0,            1, A1, 0, 1, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, 32'h0000000A, 0, 0,  0, 0, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 32'h0000000B, 0, 0,  0, 0, 0, 1, 1);

        // Reset state with both masters requesting and the bus accepting.
        #1 resetn = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = A0; m1_addr = A1; s_addr_ok = 1'b1;
        #1;
        checkOutput("reset_s_req", s_req, 0);
        checkOutput("reset_m0_addr_ok", m0_addr_ok, 0);
        checkOutput("reset_m1_addr_ok", m1_addr_ok, 0);
        checkOutput("reset_data_ok", {m1_data_ok, m0_data_ok}, 0);
        checkOutput("reset_busy", busy, 0);
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            applyStimulus(tbl[i].in);
            checkOutput({t, "_s_req"}, s_req, tbl[i].sreq);
            if (tbl[i].sreq) checkOutput({t, "_s_addr"}, s_addr, tbl[i].saddr);
            checkOutput({t, "_addr_ok"}, {m1_addr_ok, m0_addr_ok}, {tbl[i].aok1, tbl[i].aok0});
            checkOutput({t, "_data_ok"}, {m1_data_ok, m0_data_ok}, {tbl[i].dok1, tbl[i].dok0});
            checkOutput({t, "_busy"}, busy, tbl[i].busy);
            if (tbl[i].dok0) checkOutput({t, "_m0_rdata"}, m0_rdata, tbl[i].rdata);
            if (tbl[i].dok1) checkOutput({t, "_m1_rdata"}, m1_rdata, tbl[i].rdata);
            model_step(t, e);
        end

        // FIFO full: four accepted m1 reads block the fifth until a pop.
        for (int i = 0; i < OUTS_DEPTH; i++) begin
            stim_t s;
            s = mk_stim(0, 1, 1, 0, 0);
            s.m1_addr = A1 + 32'(i * 16);
            do_cycle("fill", s);
        end
        do_cycle("full_block", mk_stim(0, 1, 1, 0, 0));
        do_cycle("full_block", mk_stim(0, 1, 1, 0, 0));
        do_cycle("full_pop", mk_stim(0, 1, 1, 1, 32'h5555AAAA));
        do_cycle("full_regrant", mk_stim(0, 1, 1, 0, 0));
        drain("full_drain");

        // Push and pop every cycle across pointer wrap.
        do_cycle("pp_pre", mk_stim(1, 0, 1, 0, 0));
        do_cycle("pp_pre", mk_stim(0, 1, 1, 0, 0));
        for (int i = 0; i < 10; i++) begin
            bit who;
            who = ((i / 2) % 2) == 1;
            do_cycle("pushpop", mk_stim(!who, who, 1, 1, $urandom));
        end
        drain("pp_drain");

        // Reset pulsed in LOCK1 with two requests outstanding.
        do_cycle("rl_pre", mk_stim(1, 0, 1, 0, 0));
        do_cycle("rl_pre", mk_stim(1, 0, 1, 0, 0));
        do_cycle("rl_lock", mk_stim(0, 1, 0, 0, 0));
        do_cycle("rl_lock", mk_stim(0, 1, 0, 0, 0));
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        resetn = 1'b0;
        #1;
        checkOutput("rl_s_req", s_req, 0);
        checkOutput("rl_addr_ok", {m1_addr_ok, m0_addr_ok}, 0);
        checkOutput("rl_data_ok", {m1_data_ok, m0_data_ok}, 0);
        checkOutput("rl_busy", busy, 0);
        model_reset();
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1 checkOutput("rl_busy_after", busy, 0);
        do_cycle("rl_first", mk_stim(1, 1, 1, 0, 0));
        drain("rl_drain");

`ifdef SRAM_ARB_RR_EN
        // Round-robin alternation from reset under continuous contention.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk_stim(1, 1, 1, q.size() > 0, $urandom));
            checkOutput($sformatf("rr_grant%0d", i), {m1_addr_ok, m0_addr_ok},
                        (i % 2 == 1) ? 64'd2 : 64'd1);
            model_step("rr", e);
        end
        drain("rr_drain");
`endif

        // Randomized traffic against the model.
        rq[0] = 0; rq[1] = 0;
        ad[0] = 0; ad[1] = 0;
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] && $urandom_range(1, 0) == 1) begin
                    rq[n] = 1;
                    ad[n] = $urandom;
                end
            end
            s.m0_req = rq[0]; s.m1_req = rq[1];
            s.m0_addr = ad[0]; s.m1_addr = ad[1];
            s.s_aok = $urandom_range(1, 0) == 1;
            s.s_dok = (q.size() > 0) && ($urandom_range(2, 0) == 0);
            s.s_rdata = $urandom;
            applyStimulus(s);
            model_step("rand", e);
            if (e.aok0) rq[0] = 0;
            if (e.aok1) rq[1] = 0;
        end
        // Let any locked request complete, then empty the FIFO.
        for (int i = 0; i < 4 && lock >= 0; i++) begin
            do_cycle("rand_unlock", mk_stim(rq[0], rq[1], 1, 0, 0));
        end
        drain("rand_drain");
        applyStimulus(idle_s);
        model_step("final", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Two-master arbiter for the sram-like req/addr_ok/data_ok memory protocol.
- Port 0 is instruction fetch; port 1 is the exe-stage data port.
- Muxes both masters onto one downstream sram-like port, which later feeds the AXI bridge.
- Records the granted master of every accepted request in an in-order ID FIFO, so each data_ok/rdata returns to its issuer.

Parameters:
- OUTS_DEPTH, 4, max outstanding accepted-but-unanswered requests; power of 2, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  master request, held stable until addr_ok.
- m0_wr / m1_wr  in  1  1 = write.
- m0_size / m1_size  in  2  0 = byte, 1 = half, 2 = word.
- m0_wstrb / m1_wstrb  in  DATA_W/8  byte write strobes.
- m0_addr / m1_addr  in  ADDR_W  request address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_addr_ok / m1_addr_ok  out  1  request accepted this cycle.
- m0_data_ok / m1_data_ok  out  1  response for this master this cycle.
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with data_ok.
- s_req  out  1  downstream request.
- s_wr  out  1  downstream write flag.
- s_size  out  2  downstream size.
- s_wstrb  out  DATA_W/8  downstream strobes.
- s_addr  out  ADDR_W  downstream address.
- s_wdata  out  DATA_W  downstream write data.
- s_addr_ok  in  1  downstream accept.
- s_data_ok  in  1  downstream response; responses arrive strictly in issue order.
- s_rdata  in  DATA_W  downstream read data.
- busy  out  1  at least one request is outstanding or locked.

Behaviour:
- Reset values:
  - All *_addr_ok, *_data_ok, s_req and busy are 0.
  - FIFO pointers and count are 0; grant FSM is in IDLE.
  - rdata outputs are don't-care.
- Grant FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - Grant condition: fifo_cnt < OUTS_DEPTH and at least one mN_req.
  - Winner (default): fixed priority, m1 over m0.
  - s_req is driven combinationally from the winner in the same cycle (zero-cycle arbitration).
  - Winner accepted (s_addr_ok=1) in that cycle: stay IDLE.
  - Winner not accepted: go to LOCKn.
- LOCKn:
  - s_* is driven from master n only; the other master is ignored.
  - Stays until s_addr_ok=1, then returns to IDLE.
  - Loser requests are never dropped, only delayed.
- mN_addr_ok = s_addr_ok and s_req and (selected master == N); it is never asserted to the non-selected master.
- Accept event (s_req and s_addr_ok): push the selected master ID (1 bit) into the FIFO.
- Response event (s_data_ok):
  - Pop the FIFO head.
  - Assert m[head]_data_ok in the same cycle with rdata = s_rdata.
  - The other master's data_ok stays 0.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- Pointers wrap modulo OUTS_DEPTH.
- FIFO full: s_req forced 0 in IDLE, so no new grant. A LOCK state cannot arise while full.
- s_data_ok with an empty FIFO is a protocol error:
  - Ignored; no master data_ok is asserted.
  - Flagged by simulation assertion.
- Write responses pop the FIFO the same way as reads.
- busy = (fifo_cnt != 0) or (state != IDLE).
- resetn asserted mid-transaction clears the FIFO and FSM immediately; in-flight responses are lost. Resetting the downstream together with the arbiter is the system's responsibility.
- Latency:
  - Request path: combinational, 0 cycles.
  - Response path: combinational, 0 cycles.
  - No added register stage.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register, reset to 1, updates on every accept event.
  - On a tie in IDLE, the master other than last_grant wins.
- Undefined: fixed priority, m1 over m0; no last_grant register.

Decomposition:
- Shared package sram_arb_pkg holds:
  - SIZE_BYTE/HALF/WORD constants;
  - MASTER_INST = 0 and MASTER_DATA = 1 IDs;
  - FSM state encodings.
- Natural sub-module: arb_id_fifo, a parameterised 1-bit-wide synchronous FIFO with cnt, full, empty and simultaneous push/pop.

Test Plan:
- Both reqs in the same cycle, s_addr_ok=1 at once:
  - Default build: m1_addr_ok=1, m0_addr_ok=0.
  - Next cycle m0 is granted.
  - s_data_ok on two cycles returns m1_data_ok then m0_data_ok, with rdata 0x11111111 and 0x22222222 routed correctly.
- m0 req, s_addr_ok held 0 for 3 cycles, m1 req appears in cycle 1:
  - s_addr stays at m0's address 0x1C000000 through cycle 3 (LOCK0).
  - m1 is granted only after m0 is accepted.
- Four m1 reads accepted with no response (OUTS_DEPTH=4):
  - 5th request gets s_req=0 until one s_data_ok.
  - In the cycle of that pop, the 5th request may be granted.
- Push and pop in the same cycle, repeated 10 cycles: fifo count stays constant, busy=1, IDs stay ordered across pointer wrap.
- resetn pulsed low mid-LOCK1 with 2 outstanding: all outputs are 0 asynchronously, busy=0 after release, and the first post-reset grant behaves as from reset.
- SRAM_ARB_RR_EN defined, both reqs continuously asserted, s_addr_ok=1 every cycle: grants alternate m0, m1, m0, m1.
